// File: rtl/enemy_unit_ctrl.sv
// enemy_unit_ctrl: per-slot enemy controller (spawn, walk, attack cycle, HP, death) feeding the sprite address generator.
// Define ENEMY_KNOCKBACK_EN to push the enemy back once per life when damage drops it below half HP.
module enemy_unit_ctrl #(
`ifdef ENEMY_KNOCKBACK_EN
  parameter logic [9:0] KB_DIST    = 10'd32,
`endif
  parameter logic [9:0] X_SPAWN    = 10'd40,
  parameter logic [9:0] X_MAX      = 10'd560,
  parameter logic [9:0] GROUND_Y   = 10'd400,
  parameter int         ANIM_TICKS = 8,
  parameter int         CD_TICKS   = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_spawn,
  input  logic [2:0] i_spawn_type,
  input  logic       i_target_in_range,
  input  logic       i_dmg_valid,
  input  logic [7:0] i_dmg,
  output logic [2:0] o_type,
  output logic [2:0] o_state,
  output logic [9:0] o_x_pos,
  output logic [9:0] o_y_pos,
  output logic [7:0] o_hp,
  output logic       o_alive,
  output logic       o_attack_pulse
);
  localparam int CW = $clog2((CD_TICKS > ANIM_TICKS) ? CD_TICKS : ANIM_TICKS);
  localparam logic [CW-1:0] ANIM_LAST = CW'(ANIM_TICKS - 1);
  localparam logic [CW-1:0] CD_LAST   = CW'(CD_TICKS - 1);

  typedef enum logic [2:0] {
    ST_NONE = 3'd0,
    MOVE_0  = 3'd1,
    MOVE_1  = 3'd2,
    MOVE_2  = 3'd3,
    ATT_CD  = 3'd4,
    ATT_0   = 3'd5,
    ATT_1   = 3'd6,
    ATT_2   = 3'd7
  } state_t;

  state_t        r_state, w_state_nx;
  logic [2:0]    r_type, w_type_nx;
  logic [9:0]    r_x, w_x_nx;
  logic [9:0]    r_y, w_y_nx;
  logic [7:0]    r_hp, w_hp_nx;
  logic          r_alive, w_alive_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic          r_pulse, w_pulse_nx;
  logic          w_spawn_ok;
  logic [7:0]    w_spawn_hp;
  logic [9:0]    w_spawn_h;
  logic [9:0]    w_speed;
  logic [10:0]   w_x_sum;
  logic [9:0]    w_x_step;
  logic [7:0]    w_hp_dmg;
  logic          w_anim_end;
  logic          w_cd_end;
`ifdef ENEMY_KNOCKBACK_EN
  logic          r_kb_done, w_kb_done_nx;
  logic [7:0]    w_type_hp;
  logic [7:0]    w_half;
  assign w_type_hp = (r_type == 3'd1) ? 8'd40 : (r_type == 3'd2) ? 8'd120 :
                     (r_type == 3'd3) ? 8'd200 : 8'd250;
  assign w_half    = w_type_hp >> 1;
`endif

  // Types outside 1..4 have no table entry and are treated like CH_None.
  assign w_spawn_ok = i_spawn && !r_alive && (i_spawn_type != 3'd0) && (i_spawn_type <= 3'd4);
  assign w_spawn_hp = (i_spawn_type == 3'd1) ? 8'd40 : (i_spawn_type == 3'd2) ? 8'd120 :
                      (i_spawn_type == 3'd3) ? 8'd200 : 8'd250;
  assign w_spawn_h  = (i_spawn_type == 3'd1) ? 10'd15 : (i_spawn_type == 3'd3) ? 10'd20 : 10'd30;
  assign w_speed    = (r_type == 3'd1) ? 10'd2 : 10'd1;
  assign w_x_sum    = {1'b0, r_x} + {1'b0, w_speed};
  assign w_x_step   = (w_x_sum > {1'b0, X_MAX}) ? X_MAX : w_x_sum[9:0];
  assign w_hp_dmg   = (i_dmg >= r_hp) ? 8'd0 : r_hp - i_dmg;
  assign w_anim_end = r_cnt == ANIM_LAST;
  assign w_cd_end   = r_cnt == CD_LAST;

  always_comb begin
    w_state_nx = r_state;
    w_type_nx  = r_type;
    w_x_nx     = r_x;
    w_y_nx     = r_y;
    w_hp_nx    = r_hp;
    w_alive_nx = r_alive;
    w_cnt_nx   = r_cnt;
`ifdef ENEMY_KNOCKBACK_EN
    w_kb_done_nx = r_kb_done;
`endif
    if (w_spawn_ok) begin
      w_state_nx = MOVE_0;
      w_type_nx  = i_spawn_type;
      w_x_nx     = X_SPAWN;
      w_y_nx     = GROUND_Y - w_spawn_h;
      w_hp_nx    = w_spawn_hp;
      w_alive_nx = 1'b1;
      w_cnt_nx   = '0;
`ifdef ENEMY_KNOCKBACK_EN
      w_kb_done_nx = 1'b0;
`endif
    end else if (r_alive) begin
      if (i_tick) begin
        w_cnt_nx = r_cnt + 1'b1;
        case (r_state)
          MOVE_0, MOVE_1, MOVE_2: begin
            if (i_target_in_range) begin
              w_state_nx = ATT_0;
              w_cnt_nx   = '0;
            end else begin
              w_x_nx = w_x_step;
              if (w_anim_end) begin
                w_state_nx = (r_state == MOVE_2) ? MOVE_0 : state_t'(r_state + 3'd1);
                w_cnt_nx   = '0;
              end
            end
          end
          ATT_0, ATT_1, ATT_2: begin
            if (w_anim_end) begin
              w_state_nx = (r_state == ATT_2) ? ATT_CD : state_t'(r_state + 3'd1);
              w_cnt_nx   = '0;
            end
          end
          ATT_CD: begin
            if (w_cd_end) begin
              w_state_nx = i_target_in_range ? ATT_0 : MOVE_0;
              w_cnt_nx   = '0;
            end
          end
          default: w_cnt_nx = '0;
        endcase
      end
      // Damage is evaluated after the tick so death or knockback overrides any advance.
      if (i_dmg_valid) begin
        w_hp_nx = w_hp_dmg;
        if (w_hp_dmg == 8'd0) begin
          w_state_nx = ST_NONE;
          w_type_nx  = 3'd0;
          w_alive_nx = 1'b0;
          w_cnt_nx   = '0;
          w_x_nx     = r_x;
        end
`ifdef ENEMY_KNOCKBACK_EN
        else if (!r_kb_done && (r_hp >= w_half) && (w_hp_dmg < w_half)) begin
          w_x_nx       = (r_x > KB_DIST) ? r_x - KB_DIST : 10'd0;
          w_state_nx   = MOVE_0;
          w_cnt_nx     = '0;
          w_kb_done_nx = 1'b1;
        end
`endif
      end
    end
    w_pulse_nx = (w_state_nx == ATT_2) && (r_state != ATT_2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_NONE;
      r_type  <= 3'd0;
      r_x     <= 10'd0;
      r_y     <= 10'd0;
      r_hp    <= 8'd0;
      r_alive <= 1'b0;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
`ifdef ENEMY_KNOCKBACK_EN
      r_kb_done <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_type  <= w_type_nx;
      r_x     <= w_x_nx;
      r_y     <= w_y_nx;
      r_hp    <= w_hp_nx;
      r_alive <= w_alive_nx;
      r_cnt   <= w_cnt_nx;
      r_pulse <= w_pulse_nx;
`ifdef ENEMY_KNOCKBACK_EN
      r_kb_done <= w_kb_done_nx;
`endif
    end
  end

  assign o_type         = r_type;
  assign o_state        = r_state;
  assign o_x_pos        = r_x;
  assign o_y_pos        = r_y;
  assign o_hp           = r_hp;
  assign o_alive        = r_alive;
  assign o_attack_pulse = r_pulse;
endmodule
